// File: rtl/nios_system_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_cpu_mul_seq
// Purpose  : Multi-cycle multiply sequencer for the CPU multiply cell. It
//            splits 32-bit operands into 16-bit halves. It issues four
//            zero-extended partial products through a registered 32x32 cell,
//            and builds the 64-bit product from the returned low words. It
//            then returns the low word (mul) or the high word
//            (mulxuu/mulxsu/mulxss) to M-stage writeback.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            start, op        - request (sampled in IDLE), operation select
//            src_a, src_b     - operands, captured when start is accepted
//            busy, done       - in-progress flag, one-cycle completion pulse
//            result           - selected product word, held until next done
//            cell_src1/2      - operands driven to the multiply cell
//            cell_result      - low 32 bits of cell product, CELL_LATENCY later
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_cpu_mul_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    input  logic [31:0] cell_result
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_issue   = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_correct = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    localparam logic [1:0] c_op_mul    = 2'b00;
    localparam logic [1:0] c_op_mulxuu = 2'b01;
    localparam logic [1:0] c_op_mulxsu = 2'b10;
    localparam logic [1:0] c_op_mulxss = 2'b11;

    localparam logic [1:0] c_wait_last = 2'(CELL_LATENCY - 1);

    logic [2:0]                   r_state;
    logic [31:0]                  r_a;
    logic [31:0]                  r_b;
    logic [1:0]                   r_op;
    logic [1:0]                   r_issue_cnt;
    logic [1:0]                   r_wait_cnt;
    logic [63:0]                  r_acc;
    logic [31:0]                  r_result;
    // Each issued partial product carries a valid bit and its index through
    // a pipe matching the cell latency, so the accumulator only ever takes
    // cell_result when a real partial product is arriving.
    logic [CELL_LATENCY-1:0]      r_tag_vld;
    logic [CELL_LATENCY-1:0][1:0] r_tag_idx;

    logic        w_issue;
    logic        w_tag_hit;
    logic [1:0]  w_tag_idx;
    logic [63:0] w_addend;
    logic [31:0] w_corr;
    logic [31:0] w_sel;

    assign w_issue   = (r_state == c_st_issue);
    assign w_tag_hit = r_tag_vld[CELL_LATENCY-1];
    assign w_tag_idx = r_tag_idx[CELL_LATENCY-1];

    assign busy   = (r_state == c_st_issue) || (r_state == c_st_wait) ||
                    (r_state == c_st_correct);
    assign done   = (r_state == c_st_done);
    assign result = r_result;

    // Issue order: ll, lh, hl, hh; zero outside ISSUE.
    always_comb begin
        cell_src1 = 32'h0;
        cell_src2 = 32'h0;
        if (w_issue) begin
            case (r_issue_cnt)
                2'd0: begin
                    cell_src1 = {16'h0, r_a[15:0]};
                    cell_src2 = {16'h0, r_b[15:0]};
                end
                2'd1: begin
                    cell_src1 = {16'h0, r_a[15:0]};
                    cell_src2 = {16'h0, r_b[31:16]};
                end
                2'd2: begin
                    cell_src1 = {16'h0, r_a[31:16]};
                    cell_src2 = {16'h0, r_b[15:0]};
                end
                default: begin
                    cell_src1 = {16'h0, r_a[31:16]};
                    cell_src2 = {16'h0, r_b[31:16]};
                end
            endcase
        end
    end

    // Weight of the returning partial product by its index.
    always_comb begin
        case (w_tag_idx)
            2'd0:    w_addend = {32'h0, cell_result};
            2'd1,
            2'd2:    w_addend = {16'h0, cell_result, 16'h0};
            default: w_addend = {cell_result, 32'h0};
        endcase
    end

    // The accumulator holds the unsigned product. Signed high words subtract
    // the other operand for each negative operand (two's-complement identity
    // A_s = A_u - 2^32*A[31]).
    always_comb begin
        w_corr = 32'h0;
        case (r_op)
            c_op_mulxss: w_corr = (r_a[31] ? r_b : 32'h0) + (r_b[31] ? r_a : 32'h0);
            c_op_mulxsu: w_corr = r_a[31] ? r_b : 32'h0;
            c_op_mulxuu: w_corr = 32'h0;
            default:     w_corr = 32'h0;
        endcase
        w_sel = (r_op == c_op_mul) ? r_acc[31:0] : (r_acc[63:32] - w_corr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_a         <= 32'h0;
            r_b         <= 32'h0;
            r_op        <= 2'b00;
            r_issue_cnt <= 2'd0;
            r_wait_cnt  <= 2'd0;
            r_acc       <= 64'h0;
            r_result    <= 32'h0;
            r_tag_vld   <= '0;
            r_tag_idx   <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_idx[0] <= r_issue_cnt;
            for (int i = 1; i < CELL_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end

            if (w_tag_hit) begin
                r_acc <= r_acc + w_addend;
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a         <= src_a;
                        r_b         <= src_b;
                        r_op        <= op;
                        r_acc       <= 64'h0;
                        r_issue_cnt <= 2'd0;
                        r_state     <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_issue_cnt <= r_issue_cnt + 2'd1;
                    if (r_issue_cnt == 2'd3) begin
                        r_wait_cnt <= 2'd0;
                        r_state    <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    r_wait_cnt <= r_wait_cnt + 2'd1;
                    if (r_wait_cnt == c_wait_last) begin
                        r_state <= c_st_correct;
                    end
                end
                c_st_correct: begin
                    r_result <= w_sel;
                    r_state  <= c_st_done;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_cpu_mul_seq
// Purpose  : Self-checking bench for nios_system_cpu_mul_seq. Two instances
//            (cell latency 1 and 2) each drive a behavioural registered
//            multiply cell. Expected results and done cycles are queued when a
//            start is driven and compared when done appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_system_cpu_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic        reset;
    logic        start1, start2;
    logic [1:0]  op1, op2;
    logic [31:0] a1, b1, a2, b2;
    logic        busy1, done1, busy2, done2;
    logic [31:0] result1, cs1_1, cs2_1, cr_1;
    logic [31:0] result2, cs1_2, cs2_2, cr_2;

    nios_system_cpu_mul_seq #(.CELL_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1),
        .src_a(a1), .src_b(b1), .busy(busy1), .done(done1), .result(result1),
        .cell_src1(cs1_1), .cell_src2(cs2_1), .cell_result(cr_1)
    );

    nios_system_cpu_mul_seq #(.CELL_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op2),
        .src_a(a2), .src_b(b2), .busy(busy2), .done(done2), .result(result2),
        .cell_src1(cs1_2), .cell_src2(cs2_2), .cell_result(cr_2)
    );

    // Behavioural multiply cells: registered low-word products.
    logic [31:0] cell1_q;
    logic [31:0] cell2_q0, cell2_q1;
    always @(posedge clk) begin
        cell1_q  <= cs1_1 * cs2_1;
        cell2_q0 <= cs1_2 * cs2_2;
        cell2_q1 <= cell2_q0;
    end
    assign cr_1 = cell1_q;
    assign cr_2 = cell2_q1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1_e, m2_e;

    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'b10:   p = {{32{a[31]}}, a} * {32'h0, b};
            2'b11:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: p = {32'h0, a} * {32'h0, b};
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard: pop an expectation whenever done is seen.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) flag("dut1_unexpected_done");
            else begin
                m1_e = q1.pop_front();
                chk("dut1_result", result1, m1_e.res);
                chk("dut1_done_cycle", cyc, m1_e.cyc);
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) flag("dut2_unexpected_done");
            else begin
                m2_e = q2.pop_front();
                chk("dut2_result", result2, m2_e.res);
                chk("dut2_done_cycle", cyc, m2_e.cyc);
            end
        end
        chk("dut1_busy_done_overlap", busy1 & done1, 0);
        chk("dut2_busy_done_overlap", busy2 & done2, 0);
    end

    task automatic wait_drain(input int which, input string nm);
        int n;
        n = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, (which == 1) ? q1.size() : q2.size(), 0);
    endtask

    // One operation on the latency-1 instance with per-cycle busy and
    // cell operand checks; operands are scrambled after capture.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int          t0;
        logic [31:0] e1, e2;
        @(negedge clk);
        op1 = op; a1 = a; b1 = b; start1 = 1'b1;
        t0 = cyc;
        q1.push_back(exp_t'{exp, t0 + 7});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            a1 = $urandom; b1 = $urandom; op1 = 2'($urandom_range(0, 3));
            chk("op_busy", busy1, (k <= 6) ? 1 : 0);
            case (k)
                1:       begin e1 = {16'h0, a[15:0]};  e2 = {16'h0, b[15:0]};  end
                2:       begin e1 = {16'h0, a[15:0]};  e2 = {16'h0, b[31:16]}; end
                3:       begin e1 = {16'h0, a[31:16]}; e2 = {16'h0, b[15:0]};  end
                4:       begin e1 = {16'h0, a[31:16]}; e2 = {16'h0, b[31:16]}; end
                default: begin e1 = 32'h0;             e2 = 32'h0;             end
            endcase
            chk("op_cell_src1", cs1_1, e1);
            chk("op_cell_src2", cs2_1, e2);
        end
        wait_drain(1, "op_done_seen");
    endtask

    initial begin
        vec_t vt[12];
        int   t0;

        reset = 1'b1;
        start1 = 1'b0; op1 = 2'b00; a1 = 32'h0; b1 = 32'h0;
        start2 = 1'b0; op2 = 2'b00; a2 = 32'h0; b2 = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_result1", result1, 0);
        chk("rst_cs1_1", cs1_1, 0);
        chk("rst_cs2_1", cs2_1, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_result2", result2, 0);
        reset = 1'b0;

        vt[0] = '{2'b00, 32'd7,         32'd6,         32'h0000002A};
        vt[1] = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE};
        vt[2] = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
        vt[3] = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000};
        vt[4] = '{2'b11, 32'h80000000,  32'h80000000,  32'h40000000};
        vt[5] = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF};
        vt[6] = '{2'b11, 32'h80000000,  32'h7FFFFFFF,  32'h0};
        vt[7] = '{2'b10, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h0};
        for (int i = 8; i < 12; i++) begin
            vt[i].op = 2'(i);
            vt[i].a  = $urandom;
            vt[i].b  = $urandom;
        end
        for (int i = 6; i < 12; i++) vt[i].exp = ref_mul(vt[i].op, vt[i].a, vt[i].b);

        for (int i = 0; i < 12; i++) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp);

        // start held high; operands change after capture.
        @(negedge clk);
        t0 = cyc;
        op1 = 2'b00; a1 = 32'd3; b1 = 32'd5; start1 = 1'b1;
        q1.push_back(exp_t'{32'h0000000F, t0 + 7});
        q1.push_back(exp_t'{32'd100, t0 + 15});
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 2) begin a1 = 32'd10; b1 = 32'd10; end
            chk("hold_busy", busy1, ((k <= 6) || (k >= 9 && k <= 14)) ? 1 : 0);
        end
        start1 = 1'b0;
        @(negedge clk);
        chk("hold_idle_after_done", busy1, 0);
        wait_drain(1, "hold_done_seen");

        // Reset in the middle of an operation.
        @(negedge clk);
        op1 = 2'b11; a1 = 32'hDEADBEEF; b1 = 32'h12345678; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_result", result1, 0);
        chk("abort_cs1", cs1_1, 0);
        chk("abort_cs2", cs2_1, 0);
        @(negedge clk);
        t0 = cyc;
        op1 = 2'b00; a1 = 32'd2; b1 = 32'd9; start1 = 1'b1;
        q1.push_back(exp_t'{32'd18, t0 + 7});
        @(negedge clk);
        start1 = 1'b0;
        wait_drain(1, "abort_restart_done_seen");

        // Cell latency 2.
        @(negedge clk);
        t0 = cyc;
        op2 = 2'b01; a2 = 32'h12345678; b2 = 32'h9ABCDEF0; start2 = 1'b1;
        q2.push_back(exp_t'{32'h0B00EA4E, t0 + 8});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk("lat2_busy", busy2, (k <= 7) ? 1 : 0);
        end
        wait_drain(2, "lat2_done_seen");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            t0 = cyc;
            op2 = 2'(i + 1); a2 = $urandom; b2 = $urandom; start2 = 1'b1;
            q2.push_back(exp_t'{ref_mul(op2, a2, b2), t0 + 8});
            @(negedge clk);
            start2 = 1'b0;
            wait_drain(2, "lat2_rand_done_seen");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
